cascade_mod_counter: RTL and testbench

CASCADE_MOD_COUNTER -- requirements
Module: cascade_mod_counter

---
 rtl/cascade_mod_counter_pkg.sv | 13 +
 rtl/cascade_mod_counter_mod_digit.sv | 67 ++++++
 rtl/cascade_mod_counter.sv | 94 +++++++++
 tb/tb_cascade_mod_counter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cascade_mod_counter_pkg.sv
// Shared constants for the cascaded modulo counter: default geometry and
// the up/down direction encoding used by the top and the digit cells.
// No logic; imported by cascade_mod_counter and mod_digit.
package cascade_mod_counter_pkg;

   localparam int DEFAULT_WIDTH  = 4;
   localparam int DEFAULT_DIGITS = 4;

   // Value of up_dn selecting each counting direction.
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/cascade_mod_counter_mod_digit.sv
// One counter digit: value register, terminal detect, step/wrap/clamp.
// Latency: count reflects clr/load/step one clock after the sampling edge.
// Backpressure: none; step is a one-cycle command from the chain logic.
// Ports: clk/reset (async active-high), clr > load > step command inputs,
//        load_val/lim digit operands, up_dn direction,
//        count registered value, term combinational terminal flag.
module mod_digit
   import cascade_mod_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load,
   input  logic             step,
   input  logic             up_dn,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] lim,
   output logic [WIDTH-1:0] count,
   output logic             term
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] step_val;

   always_comb begin
      // Up counting treats anything at or above lim as terminal, so a digit
      // left above a lowered lim wraps on its next step instead of running on.
      term = (up_dn == DIR_UP) ? (count_q >= lim) : (count_q == '0);

      step_val = count_q;
      if (up_dn == DIR_UP) begin
         // Not terminal implies count_q < lim, so +1 cannot overflow.
         step_val = term ? '0 : count_q + WIDTH'(1);
      end else begin
         // Zero wraps to lim; an out-of-range value snaps back to lim.
         if ((count_q == '0) || (count_q > lim)) begin
            step_val = lim;
         end else begin
            step_val = count_q - WIDTH'(1);
         end
      end

      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = (load_val > lim) ? lim : load_val;
      end else if (step) begin
         count_d = step_val;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/cascade_mod_counter.sv
// Cascaded per-digit modulo counter with saturate/wrap and a parked flag.
// Latency: count and hold update one clock after the sampling edge; tc is combinational.
// Backpressure: none; en is accepted every cycle it is high.
// Ports: clk, reset (async active-high), en/clr/load controls, load_val and
//        lim (digit i at [i*WIDTH +: WIDTH]), up_dn, sat,
//        count (registered), tc (combinational), hold (registered).
module cascade_mod_counter
   import cascade_mod_counter_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int DIGITS = DEFAULT_DIGITS
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    clr,
   input  logic                    load,
   input  logic [DIGITS*WIDTH-1:0] load_val,
   input  logic [DIGITS*WIDTH-1:0] lim,
   input  logic                    up_dn,
   input  logic                    sat,
   output logic [DIGITS*WIDTH-1:0] count,
   output logic                    tc,
   output logic                    hold
);

   logic [DIGITS-1:0] term;
   logic [DIGITS-1:0] step;
   logic              freeze;

   logic hold_q;
   logic hold_d;
   logic up_dn_q;
   logic up_dn_d;

   // Terminal count of the whole chain; clr/load outrank counting so they
   // also mask it.
   assign tc     = en & ~clr & ~load & (&term);
   // A saturating chain at its terminal parks instead of wrapping.
   assign freeze = sat & tc;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic lower_term;

      if (i == 0) begin : g_lsd
         assign lower_term = 1'b1;
      end else begin : g_upper
         assign lower_term = &term[i-1:0];
      end

      assign step[i] = en & lower_term & ~freeze;

      mod_digit #(
         .WIDTH (WIDTH)
      ) u_digit (
         .clk      (clk),
         .reset    (reset),
         .clr      (clr),
         .load     (load),
         .step     (step[i]),
         .up_dn    (up_dn),
         .load_val (load_val[i*WIDTH +: WIDTH]),
         .lim      (lim[i*WIDTH +: WIDTH]),
         .count    (count[i*WIDTH +: WIDTH]),
         .term     (term[i])
      );
   end

   always_comb begin
      up_dn_d = up_dn;
      hold_d  = hold_q;
      // Any event that can move the chain off its terminal releases hold;
      // otherwise it stays set even if en drops.
      if (clr || load || (up_dn != up_dn_q) || !sat) begin
         hold_d = 1'b0;
      end else if (freeze) begin
         hold_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q  <= 1'b0;
         up_dn_q <= DIR_UP;
      end else begin
         hold_q  <= hold_d;
         up_dn_q <= up_dn_d;
      end
   end

   assign hold = hold_q;

endmodule

// File: tb/tb_cascade_mod_counter.sv
// Directed bench for cascade_mod_counter, WIDTH=4, DIGITS=2, lim 59 unless noted.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-derived constants or the decimal k -> {k/10, k%10} mapping.
module tb_cascade_mod_counter;

   logic       clk;
   logic       reset;
   logic       en;
   logic       clr;
   logic       load;
   logic [7:0] load_val;
   logic [7:0] lim;
   logic       up_dn;
   logic       sat;
   logic [7:0] count;
   logic       tc;
   logic       hold;

   int checks;
   int errors;

   cascade_mod_counter #(
      .WIDTH  (4),
      .DIGITS (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .lim      (lim),
      .up_dn    (up_dn),
      .sat      (sat),
      .count    (count),
      .tc       (tc),
      .hold     (hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] dec2(input int k);
      logic [3:0] hi;
      logic [3:0] lo;
      hi = 4'(k / 10);
      lo = 4'(k % 10);
      return {hi, lo};
   endfunction

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      en       = 1'b0;
      clr      = 1'b0;
      load     = 1'b0;
      load_val = 8'h00;
      lim      = 8'h59;
      up_dn    = 1'b1;
      sat      = 1'b0;

      // Reset state and tc behaviour while reset is held.
      #2;
      chk("rst_count", count, 8'h00);
      chk("rst_hold", {7'd0, hold}, 8'h00);
      chk("rst_tc_idle", {7'd0, tc}, 8'h00);
      en = 1'b1; up_dn = 1'b0; #1;
      chk("rst_tc_down", {7'd0, tc}, 8'h01);
      up_dn = 1'b1; #1;
      chk("rst_tc_up", {7'd0, tc}, 8'h00);

      // Up, wrap mode: 00..59 then back to 00.
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         chk($sformatf("up_count_%0d", k), count, dec2(k % 60));
         chk($sformatf("up_tc_%0d", k), {7'd0, tc}, (k == 59) ? 8'h01 : 8'h00);
      end

      // Down, wrap mode: 00 -> 59 -> ... -> 00.
      up_dn = 1'b0; #1;
      chk("dn_tc_at_00", {7'd0, tc}, 8'h01);
      for (int k = 1; k <= 60; k++) begin
         tick();
         chk($sformatf("dn_count_%0d", k), count, dec2((60 - k) % 60));
         chk($sformatf("dn_tc_%0d", k), {7'd0, tc}, (k == 60) ? 8'h01 : 8'h00);
      end

      // Saturating up: park at 59, hold sticks with en low, clr releases.
      en = 1'b0; up_dn = 1'b1; load = 1'b1; load_val = 8'h58;
      tick();
      load = 1'b0;
      chk("sat_load58", count, 8'h58);
      sat = 1'b1; en = 1'b1;
      tick();
      chk("sat_reach59", count, 8'h59);
      chk("sat_tc59", {7'd0, tc}, 8'h01);
      chk("sat_hold_not_yet", {7'd0, hold}, 8'h00);
      tick();
      chk("sat_parked", count, 8'h59);
      chk("sat_hold_set", {7'd0, hold}, 8'h01);
      en = 1'b0;
      tick();
      chk("sat_hold_sticky", {7'd0, hold}, 8'h01);
      chk("sat_count_sticky", count, 8'h59);
      en = 1'b1; clr = 1'b1; #1;
      chk("clr_masks_tc", {7'd0, tc}, 8'h00);
      tick();
      clr = 1'b0; en = 1'b0;
      chk("clr_count", count, 8'h00);
      chk("clr_hold", {7'd0, hold}, 8'h00);

      // Park again, then dropping sat releases hold without moving count.
      load = 1'b1; load_val = 8'h59; en = 1'b1;
      tick();
      load = 1'b0;
      chk("sat2_load59", count, 8'h59);
      tick();
      chk("sat2_hold_set", {7'd0, hold}, 8'h01);
      sat = 1'b0; en = 1'b0;
      tick();
      chk("satoff_hold_clr", {7'd0, hold}, 8'h00);
      chk("satoff_count", count, 8'h59);

      // Load clamps per digit and beats en.
      clr = 1'b1;
      tick();
      clr = 1'b0; load = 1'b1; load_val = 8'h7C; en = 1'b1;
      tick();
      chk("load_clamp", count, 8'h59);
      load_val = 8'h23;
      tick();
      chk("load_beats_en", count, 8'h23);
      load = 1'b0; en = 1'b0;

      // Asynchronous reset between edges discards the pending step.
      load = 1'b1; load_val = 8'h37;
      tick();
      load = 1'b0; en = 1'b1;
      chk("pre_rst_37", count, 8'h37);
      #3 reset = 1'b1;
      #1;
      chk("async_rst_count", count, 8'h00);
      chk("async_rst_hold", {7'd0, hold}, 8'h00);
      @(posedge clk); #1;
      reset = 1'b0;
      tick();
      chk("post_rst_01", count, 8'h01);

      // Down with a digit above a lowered lim snaps it to lim.
      en = 1'b0; load = 1'b1; load_val = 8'h37;
      tick();
      load = 1'b0;
      lim = 8'h23; up_dn = 1'b0; en = 1'b1; #1;
      chk("dn_above_lim_tc", {7'd0, tc}, 8'h00);
      tick();
      chk("dn_above_lim", count, 8'h33);

      // Up with both digits above a lowered lim wraps the chain to 00.
      en = 1'b0; lim = 8'h59; load = 1'b1;
      tick();
      load = 1'b0;
      chk("reload_37", count, 8'h37);
      lim = 8'h23; up_dn = 1'b1; en = 1'b1; #1;
      chk("low_lim_tc", {7'd0, tc}, 8'h01);
      tick();
      chk("low_lim_wrap", count, 8'h00);

      // lim 0 on digit 0 pins it at 0; digit 1 steps every cycle.
      lim = 8'h50; #1;
      chk("lim0_tc", {7'd0, tc}, 8'h00);
      tick();
      chk("lim0_step1", count, 8'h10);
      tick();
      chk("lim0_step2", count, 8'h20);
      en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
